// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI SCLK engine: FSM encoding, SPI mode
// codes and the edge-counter width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  // SPI modes as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int SPI_DIV_W  = 9;
  localparam int SPI_BITS_W = 6;

  // Edge counter must reach 2*(2^BITS_W-1), which needs one extra bit.
  function automatic int spi_edge_w(input int bits_w);
    return bits_w + 1;
  endfunction

endpackage

// File: rtl/spi_half_period_counter.sv
// Prescaler that counts 0..hp-1 and pulses tick on the terminal count.
module spi_half_period_counter #(
  parameter int DIV_W = 9
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] hp,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // hp is never 0 here, so hp-1 cannot wrap.
  assign tick = enable && !clear && (cnt_q == (hp - DIV_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : (cnt_q + DIV_W'(1));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: bounded SCLK burst with runtime half-period, bit
// count and mode, plus launch/sample strobes and busy/done handshake.
module spi_sclk_engine
  import spi_pkg::*;
#(
  parameter int DIV_W  = SPI_DIV_W,
  parameter int BITS_W = SPI_BITS_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DIV_W-1:0]  half_period,
  input  logic [BITS_W-1:0] num_bits,
  input  logic              cpol,
  input  logic              cpha,
  output logic              sclk,
  output logic              launch_t,
  output logic              sample_t,
  output logic              busy,
  output logic              done
);

  localparam int EDGE_W = spi_edge_w(BITS_W);

  state_e            state_q, state_d, state_eff;
  logic [DIV_W-1:0]  hp_q, hp_d, hp_in, hp_eff;
  logic [BITS_W-1:0] nb_q, nb_d, nb_eff;
  logic [1:0]        mode_q, mode_d, mode_eff;
  logic [EDGE_W-1:0] edge_q, edge_d, last_edge;
  logic              sclk_q, sclk_d;
  logic              launch_q, launch_d;
  logic              sample_q, sample_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept, cancel, cnt_en, tick, lead_sample, edge_last;

  assign accept = (state_q == ST_IDLE) && start && !abort;
  assign cancel = (state_q != ST_IDLE) && abort;
  assign hp_in  = (half_period == '0) ? DIV_W'(1) : half_period;

  // The accept cycle already behaves like the first cycle of the burst, using
  // the live inputs, so edge k lands exactly (k+1)*hp cycles after accept.
  assign hp_eff   = accept ? hp_in : hp_q;
  assign nb_eff   = accept ? num_bits : nb_q;
  assign mode_eff = accept ? {cpol, cpha} : mode_q;
  assign state_eff = accept ? ((num_bits == '0) ? ST_GUARD : ST_RUN)
                   : (cancel ? ST_IDLE : state_q);

  assign lead_sample = (mode_eff == SPI_MODE0) || (mode_eff == SPI_MODE2);
  assign last_edge   = {nb_eff, 1'b0} - EDGE_W'(1);
  assign edge_last   = (edge_q == last_edge);
  assign cnt_en      = (state_eff == ST_RUN) || ((state_eff == ST_GUARD) && !done_q);

  spi_half_period_counter #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (!cnt_en),
    .enable  (cnt_en),
    .hp      (hp_eff),
    .tick    (tick)
  );

  always_comb begin
    state_d  = state_q;
    hp_d     = hp_q;
    nb_d     = nb_q;
    mode_d   = mode_q;
    edge_d   = edge_q;
    sclk_d   = mode_q[1];
    launch_d = 1'b0;
    sample_d = 1'b0;
    done_d   = 1'b0;

    if (accept) begin
      hp_d   = hp_in;
      nb_d   = num_bits;
      mode_d = {cpol, cpha};
      edge_d = '0;
    end

    unique case (state_eff)
      ST_IDLE: begin
        state_d = ST_IDLE;
        edge_d  = '0;
      end
      ST_RUN: begin
        state_d  = ST_RUN;
        launch_d = accept && lead_sample;
        if (tick) begin
          edge_d = edge_q + EDGE_W'(1);
          if (lead_sample) begin
            sample_d = !edge_q[0];
            launch_d = launch_d || (edge_q[0] && !edge_last);
          end else begin
            sample_d = edge_q[0];
            launch_d = !edge_q[0];
          end
          if (edge_last) begin
            state_d = ST_GUARD;
            edge_d  = '0;
          end
        end
        sclk_d = mode_eff[1] ^ edge_d[0];
      end
      ST_GUARD: begin
        // done is shown for one cycle while still busy; IDLE follows it.
        state_d = done_q ? ST_IDLE : ST_GUARD;
        sclk_d  = mode_eff[1];
        done_d  = tick;
      end
      default: begin
        state_d = ST_IDLE;
        edge_d  = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      hp_q     <= '0;
      nb_q     <= '0;
      mode_q   <= '0;
      edge_q   <= '0;
      sclk_q   <= 1'b0;
      launch_q <= 1'b0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hp_q     <= hp_d;
      nb_q     <= nb_d;
      mode_q   <= mode_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      launch_q <= launch_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sclk     = sclk_q;
  assign launch_t = launch_q;
  assign sample_t = sample_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Directed bench for spi_sclk_engine: cycle-by-cycle checks of SCLK, strobes
// and handshake for each mode, edge cases, abort and asynchronous reset.
module tb_spi_sclk_engine;

  localparam int DIV_W  = 9;
  localparam int BITS_W = 6;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [DIV_W-1:0]  half_period;
  logic [BITS_W-1:0] num_bits;
  logic              cpol;
  logic              cpha;
  logic              sclk;
  logic              launch_t;
  logic              sample_t;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  spi_sclk_engine #(
    .DIV_W  (DIV_W),
    .BITS_W (BITS_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .half_period (half_period),
    .num_bits    (num_bits),
    .cpol        (cpol),
    .cpha        (cpha),
    .sclk        (sclk),
    .launch_t    (launch_t),
    .sample_t    (sample_t),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input int t, input logic e_sclk, input logic e_launch,
                      input logic e_sample, input logic e_busy, input logic e_done);
    chk($sformatf("%s sclk@%0d", tag, t), sclk, e_sclk);
    chk($sformatf("%s launch@%0d", tag, t), launch_t, e_launch);
    chk($sformatf("%s sample@%0d", tag, t), sample_t, e_sample);
    chk($sformatf("%s busy@%0d", tag, t), busy, e_busy);
    chk($sformatf("%s done@%0d", tag, t), done, e_done);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Start is held during relative cycle 0; returns in relative cycle 1.
  task automatic begin_burst(input logic [DIV_W-1:0] hp, input logic [BITS_W-1:0] nb,
                             input logic pol, input logic pha);
    half_period = hp;
    num_bits    = nb;
    cpol        = pol;
    cpha        = pha;
    start       = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    half_period = '0;
    num_bits    = '0;
    cpol        = 1'b0;
    cpha        = 1'b0;
    next_cycle();
    next_cycle();
    chk5("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    next_cycle();

    // Mode 0, hp=4, 2 bits; inputs disturbed mid-burst, start in done cycle ignored
    begin_burst(9'd4, 6'd2, 1'b0, 1'b0);
    for (int t = 1; t <= 22; t++) begin
      if (t == 2) begin
        half_period = 9'd1;
        num_bits    = 6'd5;
        cpol        = 1'b1;
      end
      start = (t == 20);
      chk5("m0", t, (t >= 4 && t < 8) || (t >= 12 && t < 16), (t == 1) || (t == 8),
           (t == 4) || (t == 12), (t <= 20), (t == 20));
      next_cycle();
    end
    start = 1'b0;

    // Mode 3, hp=1, 8 bits
    begin_burst(9'd1, 6'd8, 1'b1, 1'b1);
    for (int t = 1; t <= 18; t++) begin
      chk5("m3", t, (t >= 17) ? 1'b1 : ((t % 2) == 0), (t <= 16) && ((t % 2) == 1),
           (t <= 16) && ((t % 2) == 0), (t <= 17), (t == 17));
      next_cycle();
    end

    // half_period=0 behaves as 1, mode 1, 1 bit
    begin_burst(9'd0, 6'd1, 1'b0, 1'b1);
    for (int t = 1; t <= 4; t++) begin
      chk5("hp0", t, (t == 1), (t == 1), (t == 2), (t <= 3), (t == 3));
      next_cycle();
    end

    // Zero-bit burst: guard only
    begin_burst(9'd3, 6'd0, 1'b0, 1'b0);
    for (int t = 1; t <= 4; t++) begin
      chk5("nb0", t, 1'b0, 1'b0, 1'b0, (t <= 3), (t == 3));
      next_cycle();
    end

    // abort together with start in IDLE: nothing accepted
    half_period = 9'd2;
    num_bits    = 6'd3;
    start       = 1'b1;
    abort       = 1'b1;
    next_cycle();
    start = 1'b0;
    abort = 1'b0;
    chk5("abst", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    chk5("abst", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mode 0, hp=4, 4 bits, abort at cycle 10, restart at cycle 12
    begin_burst(9'd4, 6'd4, 1'b0, 1'b0);
    for (int t = 1; t <= 11; t++) begin
      abort = (t == 10);
      chk5("abrt", t, (t >= 4 && t < 8), (t == 1) || (t == 8), (t == 4), (t <= 10), 1'b0);
      next_cycle();
    end
    abort = 1'b0;
    chk5("abrt", 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    begin_burst(9'd4, 6'd4, 1'b0, 1'b0);
    for (int t = 1; t <= 37; t++) begin
      chk5("rest", t + 12,
           (t >= 4 && t < 8) || (t >= 12 && t < 16) || (t >= 20 && t < 24) || (t >= 28 && t < 32),
           (t == 1) || (t == 8) || (t == 16) || (t == 24),
           (t == 4) || (t == 12) || (t == 20) || (t == 28),
           (t <= 36), (t == 36));
      next_cycle();
    end

    // Mode 2 burst hit by asynchronous reset at cycle 7
    begin_burst(9'd4, 6'd2, 1'b1, 1'b0);
    for (int t = 1; t <= 7; t++) begin
      chk5("m2", t, (t < 4), (t == 1), (t == 4), 1'b1, 1'b0);
      if (t < 7) next_cycle();
    end
    #1 reset_n = 1'b0;
    #1;
    chk5("arst", 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    next_cycle();
    next_cycle();
    chk5("arst", 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start   = 1'b0;
    reset_n = 1'b1;
    next_cycle();
    chk5("arst", 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    chk5("arst", 11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sclk_engine.md
Name: spi_sclk_engine

Overview:
- Parametrised successor to the fixed-rate SPI clock generator.
- Produces a bounded burst of SCLK cycles with runtime-selectable half-period, bit count and SPI mode (CPOL/CPHA).
- Emits single-cycle launch/sample strobes for the shift-register datapath, plus busy/done handshake for the transaction controller.
- Sits between the SPI master FSM (start/abort) and the MOSI/MISO shifters.

Parameters:
- DIV_W, 9: width of the half_period input; max half period 2^DIV_W-1 clocks.
- BITS_W, 6: width of num_bits; max burst 2^BITS_W-1 bits.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a burst; accepted only in IDLE.
- abort  in  1  synchronous cancel; ends the burst with no done.
- half_period  in  DIV_W  clocks per SCLK phase; sampled at accept; 0 treated as 1.
- num_bits  in  BITS_W  SCLK cycles in the burst; sampled at accept.
- cpol  in  1  idle SCLK level; sampled at accept.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled at accept.
- sclk  out  1  serial clock, registered.
- launch_t  out  1  one-cycle pulse: shifter drives the next MOSI bit.
- sample_t  out  1  one-cycle pulse: shifter captures MISO.
- busy  out  1  high from the cycle after accept through the done cycle.
- done  out  1  one-cycle pulse at normal completion.

Behaviour:
- Reset (async assert): state IDLE, sclk=0, latched cpol=0, launch_t/sample_t/busy/done=0, all counters 0. Deassertion takes effect at the next posedge.
- Every output is registered. Strobes assert in the same cycle sclk shows its new level.
- States: IDLE, RUN, GUARD.
- IDLE: sclk = latched cpol.
  - start=1 accepts at cycle A: latch parameters, clear the prescaler and edge counter.
  - num_bits=0: go straight to GUARD.
  - Otherwise go to RUN.
  - start is ignored while busy.
- Prescaler: counts 0..hp-1, where hp = max(half_period,1). At terminal count it wraps to 0 and fires an edge event.
- RUN:
  - Each edge event toggles sclk and increments the edge counter (BITS_W+1 bits).
  - Edge k (k from 0) is leading if k is even, trailing if k is odd.
  - Edge k shows on sclk at cycle A+(k+1)*hp.
  - After edge 2*num_bits-1, go to GUARD with sclk back at cpol.
- Strobe rules:
  - sample_t fires on leading edges if cpha=0, on trailing edges if cpha=1.
  - launch_t with cpha=0: fires at A+1 for bit 0, then on every trailing edge except the last.
  - launch_t with cpha=1: fires on every leading edge.
  - Each burst gives exactly num_bits launch_t and num_bits sample_t pulses.
- GUARD:
  - sclk held at cpol for hp cycles (CS hold time).
  - done=1 at cycle A+(2*num_bits+1)*hp, with busy still 1.
  - Next cycle: IDLE, busy=0.
  - start in the done cycle is ignored; earliest re-accept is the cycle after.
- abort:
  - In RUN or GUARD: next cycle IDLE, sclk=cpol, busy=0, no done, no strobes.
  - abort together with start in IDLE: abort wins, nothing accepted.
  - abort outside a burst is a no-op.
- Input changes while busy (half_period, num_bits, cpol, cpha) have no effect until the next accept.
- Width rules:
  - Prescaler is DIV_W bits and compares against hp-1; no overflow at hp = 2^DIV_W-1.
  - Edge counter is sized for 2*(2^BITS_W-1).
- Async reset mid-burst: all outputs go to reset values immediately; no done.

Decomposition:
- Package spi_pkg:
  - state encoding (IDLE/RUN/GUARD);
  - mode constants SPI_MODE0..3 as {cpol,cpha};
  - localparam for edge-counter width, BITS_W+1.
- Sub-module spi_half_period_counter:
  - parameter DIV_W;
  - ports clock, reset_n, clear, enable, hp;
  - output tick, a one-cycle pulse at terminal count.
  - Instantiated once; the FSM and strobe logic stay in spi_sclk_engine.

Test Plan:
- Mode 0, hp=4, num_bits=2, start at cycle 0 -> busy 1..20; sclk rises at 4 and 12, falls at 8 and 16; launch_t at 1 and 8; sample_t at 4 and 12; done at 20; busy=0 at 21.
- Mode 3 (cpol=1,cpha=1), hp=1, num_bits=8 -> sclk idles 1; 16 edges on cycles 1..16; launch_t on the 8 falling edges, sample_t on the 8 rising edges; done at 17.
- half_period=0, num_bits=1, mode 1 -> behaves as hp=1: edges at 1 and 2, launch_t at 1, sample_t at 2, done at 3.
- num_bits=0, hp=3 -> no sclk edges, no strobes; done at cycle 3.
- Mode 0, hp=4, num_bits=4, abort at cycle 10 -> IDLE at 11 with sclk=0, busy=0, no done; start at 12 is accepted, and the full burst completes with done at 48.
- reset_n low at cycle 7 of a mode-2 burst (cpol=1) -> immediately sclk=0, busy=0, strobes 0; start is ignored while reset_n=0.
